mem_access: RTL and testbench

- Memory-stage controller at the consumer end of the EX/MEM pipeline register.
- Takes the latched access request from EX/MEM: ALU result, destination register, memory address, store data and 2-bit rwe.
- Runs multi-cycle read/write timing against the external asynchronous 16-bit SRAM and stalls the pipeline while busy.
- Presents write-back data and destination register to MEM/WB.

---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/mem_access.sv | 172 +++++++++++++++++
 tb/tb_mem_access.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-stage controller: access types, FSM states
// and the down-counter width helper.
package mem_access_pkg;

    // Access type carried in EX/MEM rwe; 2'b11 is handled as NONE
    localparam logic [1:0] RWE_NONE  = 2'b00;
    localparam logic [1:0] RWE_READ  = 2'b01;
    localparam logic [1:0] RWE_WRITE = 2'b10;

    // Destination register value meaning "no write-back"
    localparam logic [3:0] REG_INVALID = 4'hF;

    typedef enum logic [2:0] {
        MA_IDLE     = 3'd0,
        MA_RD       = 3'd1,
        MA_WR_SETUP = 3'd2,
        MA_WR_PULSE = 3'd3,
        MA_WR_HOLD  = 3'd4,
        MA_DONE     = 3'd5
    } ma_state_t;

    // Counter holds at most max(a,b)-1, never narrower than one bit
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/mem_access.sv
// Memory-stage controller: drives an asynchronous 16-bit SRAM with multi-cycle
// read/write timing, stalls the pipeline while busy and hands write-back data
// to MEM/WB. All SRAM strobes come straight from flops.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int RD_WAIT  = 1,
    parameter int WR_PULSE = 1,
    parameter int ADDR_W   = 18
) (
    input  logic              mai_clk,
    input  logic              mai_rst,
    input  logic [15:0]       mai_data,
    input  logic [3:0]        mai_wreg_addr,
    input  logic [15:0]       mai_mem_addr,
    input  logic [15:0]       mai_write_to_mem_data,
    input  logic [1:0]        mai_rwe,
    output logic [15:0]       mao_data,
    output logic [3:0]        mao_wreg_addr,
    output logic              mao_stall,
    output logic [ADDR_W-1:0] mao_ram_addr,
    output logic [15:0]       mao_ram_dout,
    output logic              mao_ram_dout_en,
    input  logic [15:0]       mai_ram_din,
    output logic              mao_ram_ce_n,
    output logic              mao_ram_oe_n,
    output logic              mao_ram_we_n
);

    localparam int CNT_W = cnt_width(RD_WAIT, WR_PULSE);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);

    ma_state_t         state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [15:0]       rdata, rdata_nxt;
    logic              rd_flag, rd_flag_nxt;   // last access was a read
    logic [ADDR_W-1:0] ram_addr, ram_addr_nxt;
    logic [15:0]       ram_dout, ram_dout_nxt;
    logic              dout_en, dout_en_nxt;
    logic              ce_n, ce_n_nxt;
    logic              oe_n, oe_n_nxt;
    logic              we_n, we_n_nxt;
    logic              stall;
    logic [15:0]       data;

    // Next-state, next-register values and combinational pipeline outputs
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rdata_nxt    = rdata;
        rd_flag_nxt  = rd_flag;
        ram_addr_nxt = ram_addr;
        ram_dout_nxt = ram_dout;
        dout_en_nxt  = dout_en;
        ce_n_nxt     = ce_n;
        oe_n_nxt     = oe_n;
        we_n_nxt     = we_n;
        stall        = 1'b0;
        data         = mai_data;
        unique case (state)
            MA_IDLE: begin
                if (mai_rwe == RWE_READ) begin
                    stall        = 1'b1;
                    ram_addr_nxt = ADDR_W'(mai_mem_addr);
                    ce_n_nxt     = 1'b0;
                    oe_n_nxt     = 1'b0;
                    cnt_nxt      = RD_LOAD;
                    rd_flag_nxt  = 1'b1;
                    state_nxt    = MA_RD;
                end else if (mai_rwe == RWE_WRITE) begin
                    stall        = 1'b1;
                    ram_addr_nxt = ADDR_W'(mai_mem_addr);
                    ram_dout_nxt = mai_write_to_mem_data;
                    dout_en_nxt  = 1'b1;
                    ce_n_nxt     = 1'b0;
                    rd_flag_nxt  = 1'b0;
                    state_nxt    = MA_WR_SETUP;
                end
            end
            MA_RD: begin
                stall = 1'b1;
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    rdata_nxt = mai_ram_din;
                    ce_n_nxt  = 1'b1;
                    oe_n_nxt  = 1'b1;
                    state_nxt = MA_DONE;
                end
            end
            MA_WR_SETUP: begin
                // Address and data settle one cycle before WE falls
                stall     = 1'b1;
                we_n_nxt  = 1'b0;
                cnt_nxt   = WR_LOAD;
                state_nxt = MA_WR_PULSE;
            end
            MA_WR_PULSE: begin
                stall = 1'b1;
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    we_n_nxt  = 1'b1;
                    state_nxt = MA_WR_HOLD;
                end
            end
            MA_WR_HOLD: begin
                // Data bus held one cycle after WE rises for hold time
                stall       = 1'b1;
                dout_en_nxt = 1'b0;
                ce_n_nxt    = 1'b1;
                state_nxt   = MA_DONE;
            end
            MA_DONE: begin
                if (rd_flag) data = rdata;
                state_nxt = MA_IDLE;
            end
            default: state_nxt = MA_IDLE;
        endcase
        // Reset releases the pipeline immediately and passes EX/MEM through
        if (mai_rst) begin
            stall = 1'b0;
            data  = mai_data;
        end
    end

    // FSM state and wait counter
    always_ff @(posedge mai_clk) begin
        if (mai_rst) begin
            state   <= MA_IDLE;
            cnt     <= '0;
            rdata   <= '0;
            rd_flag <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdata   <= rdata_nxt;
            rd_flag <= rd_flag_nxt;
        end
    end

    // Registered SRAM bus; reset forces every strobe inactive at once
    always_ff @(posedge mai_clk) begin
        if (mai_rst) begin
            ram_addr <= '0;
            ram_dout <= '0;
            dout_en  <= 1'b0;
            ce_n     <= 1'b1;
            oe_n     <= 1'b1;
            we_n     <= 1'b1;
        end else begin
            ram_addr <= ram_addr_nxt;
            ram_dout <= ram_dout_nxt;
            dout_en  <= dout_en_nxt;
            ce_n     <= ce_n_nxt;
            oe_n     <= oe_n_nxt;
            we_n     <= we_n_nxt;
        end
    end

    assign mao_data        = data;
    assign mao_wreg_addr   = mai_wreg_addr;
    assign mao_stall       = stall;
    assign mao_ram_addr    = ram_addr;
    assign mao_ram_dout    = ram_dout;
    assign mao_ram_dout_en = dout_en;
    assign mao_ram_ce_n    = ce_n;
    assign mao_ram_oe_n    = oe_n;
    assign mao_ram_we_n    = we_n;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access with RD_WAIT=1, WR_PULSE=2 against a behavioural
// asynchronous SRAM; expected write-back values go through a scoreboard queue.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int ADDR_W = 18;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       mai_data;
    logic [3:0]        mai_wreg_addr;
    logic [15:0]       mai_mem_addr;
    logic [15:0]       mai_wdata;
    logic [1:0]        mai_rwe;
    logic [15:0]       mao_data;
    logic [3:0]        mao_wreg_addr;
    logic              stall;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_dout;
    logic              dout_en;
    logic [15:0]       ram_din;
    logic              ce_n, oe_n, we_n;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  wreg;
    } exp_t;
    exp_t sb[$];

    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    mem_access #(.RD_WAIT(1), .WR_PULSE(2), .ADDR_W(ADDR_W)) dut (
        .mai_clk(clk), .mai_rst(rst), .mai_data(mai_data),
        .mai_wreg_addr(mai_wreg_addr), .mai_mem_addr(mai_mem_addr),
        .mai_write_to_mem_data(mai_wdata), .mai_rwe(mai_rwe),
        .mao_data(mao_data), .mao_wreg_addr(mao_wreg_addr), .mao_stall(stall),
        .mao_ram_addr(ram_addr), .mao_ram_dout(ram_dout),
        .mao_ram_dout_en(dout_en), .mai_ram_din(ram_din),
        .mao_ram_ce_n(ce_n), .mao_ram_oe_n(oe_n), .mao_ram_we_n(we_n)
    );

    // Asynchronous SRAM: drives data while selected and output-enabled,
    // captures on the rising edge of WE
    assign ram_din = (!ce_n && !oe_n) ? mem[ram_addr[7:0]] : 16'hDEAD;
    always @(posedge we_n) begin
        if (!ce_n && dout_en) mem[ram_addr[7:0]] <= ram_dout;
    end

    // Issue one access, follow it to completion, check bus safety each cycle
    task automatic run_access(input logic [1:0] rwe, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] alu,
                              input logic [3:0] wreg, input logic [15:0] exp_data,
                              output int n_stall, output int n_oe, output int n_we);
        bit   done;
        exp_t e;
        @(posedge clk); #1;
        mai_rwe = rwe; mai_mem_addr = addr; mai_wdata = wdata;
        mai_data = alu; mai_wreg_addr = wreg;
        sb.push_back('{exp_data, wreg});
        n_stall = 0; n_oe = 0; n_we = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            checks++;
            if (!oe_n && dout_en) begin
                errors++; $display("FAIL bus_overlap: oe_n=%b dout_en=%b required not both active", oe_n, dout_en);
            end
            checks++;
            if (!we_n && (ce_n || !dout_en)) begin
                errors++; $display("FAIL we_window: we_n=0 with ce_n=%b dout_en=%b required ce_n=0 dout_en=1", ce_n, dout_en);
            end
            if (!oe_n) n_oe++;
            if (!we_n) n_we++;
            if (stall) n_stall++;
            else begin
                done = 1;
                e = sb.pop_front();
                checks++;
                if (mao_data !== e.data) begin
                    errors++; $display("FAIL wb_data: got %h required %h", mao_data, e.data);
                end
                checks++;
                if (mao_wreg_addr !== e.wreg) begin
                    errors++; $display("FAIL wb_wreg: got %h required %h", mao_wreg_addr, e.wreg);
                end
            end
        end
        if (!done) begin
            errors++; $display("FAIL timeout: stall still high after 40 cycles, required release");
            void'(sb.pop_front());
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        mai_rwe = RWE_NONE;
    endtask

    task automatic chk_stall(input string nm, input int got, input int req);
        // used only for cycle-count comparisons
        checks++;
        if (got !== req) begin
            errors++; $display("FAIL %s: got %0d required %0d", nm, got, req);
        end
    endtask

    task automatic test_reset();
        rst = 1; mai_rwe = RWE_WRITE; mai_data = 16'h1111; mai_wreg_addr = 4'h5;
        mai_mem_addr = 16'h0010; mai_wdata = 16'hFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || mao_data !== 16'h1111 || mao_wreg_addr !== 4'h5) begin
            errors++; $display("FAIL reset_passthru: stall=%b data=%h wreg=%h required 0/1111/5", stall, mao_data, mao_wreg_addr);
        end
        checks++;
        if ({ce_n, oe_n, we_n, dout_en} !== 4'b1110 || ram_addr !== '0 || ram_dout !== '0) begin
            errors++; $display("FAIL reset_bus: ce/oe/we/en=%b addr=%h dout=%h required 1110/0/0", {ce_n, oe_n, we_n, dout_en}, ram_addr, ram_dout);
        end
        @(posedge clk); #1;
        mai_rwe = RWE_NONE; rst = 0;
    endtask

    task automatic test_passthrough();
        int s, o, w;
        run_access(RWE_NONE, 16'h0001, 16'h0, 16'h1234, 4'h3, 16'h1234, s, o, w);
        chk_stall("pass_stall", s, 0);
        checks++;
        if ({ce_n, oe_n, we_n} !== 3'b111 || o != 0 || w != 0) begin
            errors++; $display("FAIL pass_strobes: ce/oe/we=%b required 111", {ce_n, oe_n, we_n});
        end
    endtask

    task automatic test_rwe11();
        int s, o, w;
        run_access(2'b11, 16'h0001, 16'h0, 16'h4321, 4'h9, 16'h4321, s, o, w);
        chk_stall("rwe11_stall", s, 0);
        @(negedge clk);
        checks++;
        if ({ce_n, oe_n, we_n} !== 3'b111 || stall !== 1'b0 || o != 0 || w != 0) begin
            errors++; $display("FAIL rwe11_strobes: ce/oe/we=%b stall=%b required 111/0", {ce_n, oe_n, we_n}, stall);
        end
        go_idle();
    endtask

    task automatic test_read();
        int s, o, w;
        run_access(RWE_READ, 16'h8001, 16'h0, 16'h0AAA, 4'h7, 16'hBEEF, s, o, w);
        chk_stall("read_stall", s, 2);
        chk_stall("read_oe_cycles", o, 1);
        checks++;
        if (ram_addr !== 18'h08001) begin
            errors++; $display("FAIL read_addr: got %h required 08001", ram_addr);
        end
        go_idle();
    endtask

    task automatic test_write();
        int s, o, w;
        run_access(RWE_WRITE, 16'h0040, 16'hA5A5, 16'h7777, 4'h2, 16'h7777, s, o, w);
        chk_stall("write_stall", s, 5);
        chk_stall("write_we_cycles", w, 2);
        checks++;
        if (mem[8'h40] !== 16'hA5A5) begin
            errors++; $display("FAIL write_mem: got %h required a5a5", mem[8'h40]);
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        int s, o, w;
        run_access(RWE_WRITE, 16'h0040, 16'h5A5A, 16'h0101, 4'h4, 16'h0101, s, o, w);
        chk_stall("b2b_write_stall", s, 5);
        // issued in the cycle right after DONE: no extra bubble
        run_access(RWE_READ, 16'h0040, 16'h0, 16'h0202, 4'h6, 16'h5A5A, s, o, w);
        chk_stall("b2b_read_stall", s, 2);
        go_idle();
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        @(posedge clk); #1;
        mai_rwe = RWE_WRITE; mai_mem_addr = 16'h0020; mai_wdata = 16'h3333;
        mai_data = 16'h0505; mai_wreg_addr = 4'h1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (!we_n) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rst_mid_we_seen: we_n never low, required low");
        end
        rst = 1;
        @(posedge clk); #1;
        checks++;
        if ({we_n, dout_en, ce_n, stall} !== 4'b1010) begin
            errors++; $display("FAIL rst_mid_bus: we/en/ce/stall=%b required 1010", {we_n, dout_en, ce_n, stall});
        end
        rst = 0; mai_rwe = RWE_NONE; mai_data = 16'h0606;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || mao_data !== 16'h0606 || {ce_n, we_n} !== 2'b11) begin
            errors++; $display("FAIL rst_mid_idle: stall=%b data=%h ce/we=%b required 0/0606/11", stall, mao_data, {ce_n, we_n});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        #0;
        mem[8'h01] <= 16'hBEEF;
        test_reset();
        test_passthrough();
        test_read();
        test_write();
        test_back_to_back();
        test_rwe11();
        test_reset_mid_write();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_empty: %0d left required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
